uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// A grant lasts until the message ends, MAX_BURST bytes go out, or the owner runs dry.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic               arb_busy
);

    localparam int               OW        = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);
    localparam logic [3:0]       BURST_LIM = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last_owner;
    logic [OW-1:0] next_owner;
    logic [3:0]    byte_cnt;
    logic          last_q;
    logic [7:0]    owner_byte;

    // Scan from the farthest candidate down so the one closest after last_owner wins.
    always_comb begin
        // NOTE: default assigned first so every path drives next_owner and no latch is inferred.
        next_owner = last_owner;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_owner) + k) % N_REQ])
                next_owner = OW'((int'(last_owner) + k) % N_REQ);
        end
    end

    assign owner_byte = req_data[int'(owner)*8 +: 8];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            req_ready  <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            arb_busy   <= 1'b0;
            byte_cnt   <= '0;
            last_q     <= 1'b0;
            owner      <= '0;
            last_owner <= OW'(N_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every register reads the pre-edge state.
            tx_start  <= 1'b0;
            req_ready <= '0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner    <= next_owner;
                        grant    <= ONE_HOT0 << next_owner;
                        byte_cnt <= '0;
                        last_q   <= 1'b0;
                        arb_busy <= 1'b1;
                        state    <= SEND;
                    end else begin
                        grant <= '0;
                    end
                end
                SEND: begin
                    if (!req_valid[owner]) begin
                        grant      <= '0;
                        last_owner <= owner;
                        arb_busy   <= 1'b0;
                        state      <= IDLE;
                    end else if (!tx_busy) begin
                        tx_start  <= 1'b1;
                        tx_data   <= owner_byte;
                        req_ready <= ONE_HOT0 << owner;
                        last_q    <= req_last[owner];
                        byte_cnt  <= byte_cnt + 4'd1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // The owner's inputs are not looked at again until the frame completes.
                    if (tx_done) begin
                        if (!last_q && byte_cnt < BURST_LIM) begin
                            state <= SEND;
                        end else begin
                            grant      <= '0;
                            last_owner <= owner;
                            arb_busy   <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    grant    <= '0;
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based requesters, a simple transmitter,
// and a transaction-level model of the round-robin/burst rules predicting every byte sent.
module tb_uart_tx_arbiter;

    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               tx_done;
    logic               arb_busy;

    uart_tx_arbiter #(.N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .arb_busy  (arb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         owner;
        logic [7:0] data;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0] rq [N_REQ][$];   // {last, data} per requester
    exp_t       exp_q[$];
    int         model_last = N_REQ - 1;

    int         start_cyc_q[$], done_cyc_q[$], grant_rise_q[$], grant_fall_q[$];
    int         valid_rise_q[$], busy_fall_q[$], own_q[$];
    logic [7:0] dat_q[$];
    int         ready_cnt = 0;

    bit         mon_en     = 1'b0;
    bit         force_busy = 1'b0;
    bit         untracked  = 1'b0;
    bit         tx_active  = 1'b0;
    int         tx_cnt     = 0;
    logic [7:0] tx_byte    = 8'h00;
    int         lat_lo     = 2;
    int         lat_hi     = 4;
    logic [N_REQ-1:0] prev_grant = '0;
    logic [N_REQ-1:0] prev_valid = '0;
    logic             prev_busy  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Spec rules at transaction level: round-robin from model_last, burst ends on last,
    // MAX_BURST bytes, or an empty queue (owner's valid drops).
    task automatic build_expected();
        logic [8:0] cq [N_REQ][$];
        logic [8:0] e;
        int o, cnt, idx;
        bit found;
        for (int i = 0; i < N_REQ; i++) cq[i] = rq[i];
        forever begin
            found = 1'b0;
            o = 0;
            for (int k = 1; k <= N_REQ && !found; k++) begin
                idx = (model_last + k) % N_REQ;
                if (cq[idx].size() > 0) begin
                    o = idx;
                    found = 1'b1;
                end
            end
            if (!found) break;
            cnt = 0;
            do begin
                e = cq[o].pop_front();
                exp_q.push_back('{o, e[7:0]});
                cnt++;
            end while (!e[8] && cnt < MAX_BURST && cq[o].size() > 0);
            model_last = o;
        end
    endtask

    task automatic monitor_cycle();
        exp_t e;
        logic [N_REQ-1:0] eg;
        if (!mon_en) return;
        check("grant_onehot", 32'($onehot0(grant)), 32'd1);
        check("ready_only_with_start", 32'((|req_ready) && !tx_start), 32'd0);
        if (prev_grant == '0 && grant != '0) grant_rise_q.push_back(cyc);
        if (prev_grant != '0 && grant == '0) grant_fall_q.push_back(cyc);
        prev_grant = grant;
        if (|req_ready) ready_cnt++;
        if (tx_start === 1'b1) begin
            start_cyc_q.push_back(cyc);
            own_q.push_back(onehot_idx(grant));
            dat_q.push_back(tx_data);
            if (exp_q.size() == 0) begin
                check("unexpected_tx_start", 32'd1, 32'd0);
            end else begin
                e  = exp_q.pop_front();
                eg = '0;
                eg[e.owner] = 1'b1;
                check("sb_grant", 32'(grant), 32'(eg));
                check("sb_data", 32'(tx_data), 32'(e.data));
                check("sb_ready", 32'(req_ready), 32'(eg));
                check("sb_arb_busy", 32'(arb_busy), 32'd1);
            end
        end
    endtask

    task automatic tx_model();
        tx_done = 1'b0;
        if (tx_start === 1'b1) begin
            tx_active = 1'b1;
            tx_cnt    = $urandom_range(lat_hi, lat_lo);
            tx_byte   = tx_data;
            untracked = 1'b0;
        end else if (tx_active) begin
            tx_cnt--;
            if (tx_cnt <= 0) begin
                tx_done   = 1'b1;
                tx_active = 1'b0;
                done_cyc_q.push_back(cyc);
                if (!untracked) check("tx_data_hold", 32'(tx_data), 32'(tx_byte));
            end
        end
        tx_busy = tx_active || force_busy;
        if (prev_busy && !tx_busy) busy_fall_q.push_back(cyc);
        prev_busy = tx_busy;
    endtask

    task automatic drive_requesters();
        logic [8:0] f;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                f = rq[i][0];
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = f[7:0];
                req_last[i]         = f[8];
            end else begin
                // Idle requesters present junk data that must never reach the transmitter.
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
        if (prev_valid == '0 && req_valid != '0) valid_rise_q.push_back(cyc);
        prev_valid = req_valid;
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            monitor_cycle();
            tx_model();
            drive_requesters();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input int r, input logic [7:0] d, input bit l);
        rq[r].push_back({l, d});
    endtask

    task automatic clear_logs();
        start_cyc_q.delete(); done_cyc_q.delete(); grant_rise_q.delete();
        grant_fall_q.delete(); valid_rise_q.delete(); busy_fall_q.delete();
        own_q.delete(); dat_q.delete();
        ready_cnt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals(tag);
        reset_n = 1'b1;
        model_last = N_REQ - 1;
        prev_grant = '0;
        exp_q.delete();
    endtask

    function automatic bit all_empty();
        bit r = 1'b1;
        for (int i = 0; i < N_REQ; i++) if (rq[i].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input int budget);
        int stable = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !tx_active && !arb_busy && grant == '0 && all_empty())
                stable++;
            else
                stable = 0;
            if (stable >= 3) return;
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            #1;
            if (start_cyc_q.size() >= n) return;
        end
        check("start_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Two requesters, one byte each: 0 first, then 2.
        do_reset("r033");
        clear_logs();
        lat_lo = 3; lat_hi = 3;
        @(posedge clk); #1;
        push(0, 8'hA5, 1'b1);
        push(2, 8'h3C, 1'b1);
        build_expected();
        wait_idle(400);
        check("033_starts", 32'(start_cyc_q.size()), 32'd2);
        if (start_cyc_q.size() == 2 && done_cyc_q.size() >= 1 && grant_rise_q.size() == 2) begin
            check("033_owner0", 32'(own_q[0]), 32'd0);
            check("033_data0", 32'(dat_q[0]), 32'hA5);
            check("033_owner1", 32'(own_q[1]), 32'd2);
            check("033_data1", 32'(dat_q[1]), 32'h3C);
            check("033_req_to_start", 32'(start_cyc_q[0] - valid_rise_q[0]), 32'd2);
            check("033_release_to_grant", 32'(grant_rise_q[1] - done_cyc_q[0]), 32'd2);
        end

        // Six-byte message from requester 1 split by MAX_BURST.
        do_reset("r034");
        clear_logs();
        lat_lo = 2; lat_hi = 4;
        @(posedge clk); #1;
        for (int j = 0; j < 6; j++) push(1, 8'(8'h10 + j), 1'b0);
        build_expected();
        wait_idle(600);
        check("034_starts", 32'(start_cyc_q.size()), 32'd6);
        check("034_ready_cnt", 32'(ready_cnt), 32'd6);
        check("034_grants", 32'(grant_rise_q.size()), 32'd2);
        if (start_cyc_q.size() == 6 && done_cyc_q.size() >= 4 && grant_rise_q.size() == 2) begin
            check("034_burst_gap", 32'(start_cyc_q[1] - done_cyc_q[0]), 32'd2);
            check("034_regrant", 32'(grant_rise_q[1] - done_cyc_q[3]), 32'd2);
            check("034_last_data", 32'(dat_q[5]), 32'h15);
        end

        // All four requesters busy with single-byte messages: strict rotation.
        do_reset("r035");
        clear_logs();
        @(posedge clk); #1;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N_REQ; i++) push(i, 8'(16*i + j), 1'b1);
        build_expected();
        wait_idle(800);
        check("035_starts", 32'(start_cyc_q.size()), 32'd8);
        check("035_one_start_per_grant", 32'(grant_rise_q.size()), 32'(start_cyc_q.size()));
        if (own_q.size() >= 6) begin
            check("035_order0", 32'(own_q[0]), 32'd0);
            check("035_order1", 32'(own_q[1]), 32'd1);
            check("035_order2", 32'(own_q[2]), 32'd2);
            check("035_order3", 32'(own_q[3]), 32'd3);
            check("035_order4", 32'(own_q[4]), 32'd0);
            check("035_order5", 32'(own_q[5]), 32'd1);
        end

        // Transmitter busy for 20 cycles while the arbiter sits in SEND.
        clear_logs();
        @(posedge clk); #1;
        force_busy = 1'b1;
        push(3, 8'h77, 1'b1);
        build_expected();
        repeat (20) @(negedge clk);
        #1;
        check("036_no_start_while_busy", 32'(start_cyc_q.size()), 32'd0);
        check("036_grant_held", 32'(grant), 32'b1000);
        check("036_arb_busy", 32'(arb_busy), 32'd1);
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_idle(200);
        check("036_starts", 32'(start_cyc_q.size()), 32'd1);
        if (start_cyc_q.size() == 1 && busy_fall_q.size() >= 1) begin
            check("036_start_after_busy", 32'(start_cyc_q[0] - busy_fall_q[0]), 32'd1);
            check("036_data", 32'(dat_q[0]), 32'h77);
        end

        // Owner runs dry mid-burst: release from SEND, no extra start.
        do_reset("r037");
        clear_logs();
        @(posedge clk); #1;
        push(0, 8'h20, 1'b0);
        push(0, 8'h21, 1'b0);
        build_expected();
        wait_idle(300);
        check("037_starts", 32'(start_cyc_q.size()), 32'd2);
        check("037_grant_falls", 32'(grant_fall_q.size()), 32'd1);
        if (grant_fall_q.size() == 1 && done_cyc_q.size() >= 2)
            check("037_release_time", 32'(grant_fall_q[0] - done_cyc_q[1]), 32'd2);

        // Reset during WAIT, stray tx_done afterwards, then normal service.
        do_reset("r038a");
        clear_logs();
        lat_lo = 8; lat_hi = 8;
        @(posedge clk); #1;
        push(0, 8'h55, 1'b1);
        build_expected();
        wait_starts(1, 50);
        @(negedge clk);
        reset_n    = 1'b0;
        untracked  = 1'b1;
        model_last = N_REQ - 1;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_vals("r038b");
        clear_logs();
        repeat (12) @(negedge clk);
        #1;
        check("038_stray_done_seen", 32'(done_cyc_q.size()), 32'd1);
        check("038_no_start", 32'(start_cyc_q.size()), 32'd0);
        check("038_grant_idle", 32'(grant), 32'd0);
        check("038_arb_idle", 32'(arb_busy), 32'd0);
        lat_lo = 2; lat_hi = 4;
        @(posedge clk); #1;
        push(0, 8'h66, 1'b1);
        push(2, 8'h67, 1'b1);
        build_expected();
        wait_idle(300);
        check("038_starts", 32'(start_cyc_q.size()), 32'd2);
        if (own_q.size() >= 1) check("038_first_owner", 32'(own_q[0]), 32'd0);

        // Randomized traffic against the transaction-level model.
        lat_lo = 1; lat_hi = 5;
        for (int r = 0; r < 25; r++) begin
            if (r % 8 == 7) do_reset("rnd");
            clear_logs();
            @(posedge clk); #1;
            for (int i = 0; i < N_REQ; i++) begin
                int n;
                n = $urandom_range(5, 0);
                for (int j = 0; j < n; j++) push(i, 8'($urandom), $urandom_range(3, 0) == 0);
            end
            build_expected();
            wait_idle(2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
